note_frame_receiver: RTL and testbench

- Receive end of the note link. Deserializes the 10-bit note bitmap shifted out on USB_CLK/USB_DATA by the keyboard front end.
- Presents the latched note vector plus per-note press/release pulses to the synth/scoring logic.
- Runs in the system clk domain. Both link lines are asynchronous inputs and are synchronized internally.

---
 rtl/note_frame_receiver_if.sv | 13 +
 rtl/note_frame_receiver.sv | 100 ++++++++++
 tb/tb_note_frame_receiver.sv | 125 ++++++++++++
 3 files changed

// File: rtl/note_frame_receiver_if.sv
// note_frame_receiver_if: note link pins plus decoded note outputs.
interface note_frame_receiver_if #(parameter int NBITS = 10);
    logic             USB_CLK;
    logic             USB_DATA;
    logic [NBITS-1:0] notes;
    logic             note_valid;
    logic [NBITS-1:0] note_on;
    logic [NBITS-1:0] note_off;
    logic             frame_err;
    logic             busy;
    modport master (output USB_CLK, USB_DATA, input notes, note_valid, note_on, note_off, frame_err, busy);
    modport slave  (input USB_CLK, USB_DATA, output notes, note_valid, note_on, note_off, frame_err, busy);
endinterface

// File: rtl/note_frame_receiver.sv
// note_frame_receiver: deserializes the note bitmap from the USB_CLK/USB_DATA link.
// Define NOTE_RX_PARITY_EN to append and check an even parity bit after the data bits.
module note_frame_receiver #(
    parameter int NBITS          = 10,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 11
) (
    input logic clk,
    input logic rst,
    note_frame_receiver_if.slave link
);
`ifdef NOTE_RX_PARITY_EN
    localparam int FLEN = NBITS + 1;
`else
    localparam int FLEN = NBITS;
`endif
    localparam int CW = $clog2(FLEN + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
    state_t                 state;
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_d, pend;
    logic [CW-1:0]          bit_cnt;
    logic [TO_W-1:0]        to_cnt;
    logic [FLEN-1:0]        shift;
    logic                   clk_s, data_s, rise, fall, par_ok;
    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign rise   = clk_s & ~clk_d;
    assign fall   = ~clk_s & clk_d;
`ifdef NOTE_RX_PARITY_EN
    assign par_ok = (^shift[NBITS-1:0]) == shift[NBITS];
`else
    assign par_ok = 1'b1;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            clk_sync        <= '1;
            data_sync       <= '1;
            clk_d           <= 1'b1;
            pend            <= 1'b0;
            bit_cnt         <= '0;
            to_cnt          <= '0;
            shift           <= '0;
            link.notes      <= '0;
            link.note_valid <= 1'b0;
            link.note_on    <= '0;
            link.note_off   <= '0;
            link.frame_err  <= 1'b0;
            link.busy       <= 1'b0;
        end else begin
            clk_sync        <= {clk_sync[SYNC_STAGES-2:0], link.USB_CLK};
            data_sync       <= {data_sync[SYNC_STAGES-2:0], link.USB_DATA};
            clk_d           <= clk_s;
            link.note_valid <= 1'b0;
            link.note_on    <= '0;
            link.note_off   <= '0;
            link.frame_err  <= 1'b0;
            case (state)
                IDLE: if (fall || pend) begin
                    state     <= SHIFT;
                    link.busy <= 1'b1;
                    bit_cnt   <= '0;
                    to_cnt    <= '0;
                    pend      <= 1'b0;
                end
                SHIFT: if (rise) begin
                    shift[bit_cnt] <= data_s;
                    bit_cnt        <= bit_cnt + 1'b1;
                    to_cnt         <= '0;
                    if (bit_cnt == CW'(FLEN - 1)) state <= COMMIT;
                end else if (fall) begin
                    to_cnt <= '0;
                end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    link.frame_err <= 1'b1;
                    link.busy      <= 1'b0;
                    shift          <= '0;
                    state          <= IDLE;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
                default: begin
                    // A start edge landing here is held so the next frame is not lost
                    state     <= IDLE;
                    pend      <= fall;
                    link.busy <= 1'b0;
                    if (par_ok) begin
                        link.notes      <= shift[NBITS-1:0];
                        link.note_on    <= shift[NBITS-1:0] & ~link.notes;
                        link.note_off   <= ~shift[NBITS-1:0] & link.notes;
                        link.note_valid <= 1'b1;
                    end else begin
                        link.frame_err <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_note_frame_receiver.sv
// tb_note_frame_receiver: directed frames on the note link with hand-computed results.
module tb_note_frame_receiver;
    localparam int NBITS = 10;
`ifdef NOTE_RX_PARITY_EN
    localparam int FL = NBITS + 1;
`else
    localparam int FL = NBITS;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0, n_err = 0;
    int   cyc = 0, vcnt = 0, ecnt = 0, vcyc = 0, ecyc = 0, rise_cyc = 0;
    logic [NBITS-1:0] v_notes = '0, v_on = '0, v_off = '0;
    int   v0, e0;
    note_frame_receiver_if #(.NBITS(NBITS)) link();
    note_frame_receiver dut (.clk(clk), .rst(rst), .link(link));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (link.note_valid) begin
            vcnt    <= vcnt + 1;
            vcyc    <= cyc;
            v_notes <= link.notes;
            v_on    <= link.note_on;
            v_off   <= link.note_off;
        end
        if (link.frame_err) begin
            ecnt <= ecnt + 1;
            ecyc <= cyc;
        end
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [NBITS:0] bits, input int n, input int half);
        link.USB_CLK = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i != 0) link.USB_CLK = 1'b0;
            link.USB_DATA = bits[i];
            tick(half);
            link.USB_CLK = 1'b1;
            rise_cyc = cyc;
            tick(half);
        end
        link.USB_DATA = 1'b1;
    endtask
    function automatic logic [NBITS:0] frm(input logic [NBITS-1:0] d);
`ifdef NOTE_RX_PARITY_EN
        return {^d, d};
`else
        return {1'b0, d};
`endif
    endfunction
    task automatic frame(input string tag, input logic [NBITS-1:0] d,
                         input logic [NBITS-1:0] on, input logic [NBITS-1:0] off);
        v0 = vcnt;
        send(frm(d), FL, 4);
        tick(12);
        check({tag, "_valid_cnt"}, vcnt - v0, 1);
        check({tag, "_notes"}, v_notes, d);
        check({tag, "_on"}, v_on, on);
        check({tag, "_off"}, v_off, off);
        check({tag, "_latency_ok"}, (vcyc - rise_cyc >= 4) && (vcyc - rise_cyc <= 5), 1);
    endtask
    initial begin
        link.USB_CLK  = 1'b1;
        link.USB_DATA = 1'b1;
        tick(3);
        rst = 1'b0;
        check("rst_notes", link.notes, 0);
        check("rst_busy", link.busy, 0);
        check("rst_valid", link.note_valid, 0);
        check("rst_err", link.frame_err, 0);
        tick(100);
        check("idle_valid_cnt", vcnt, 0);
        check("idle_err_cnt", ecnt, 0);
        check("idle_busy", link.busy, 0);
        frame("f005", 10'h005, 10'h005, 10'h000);
        frame("f204", 10'h204, 10'h200, 10'h001);
        frame("f204_rep", 10'h204, 10'h000, 10'h000);
        // Stall mid-frame with USB_CLK held high until the timeout fires
        v0 = vcnt;
        e0 = ecnt;
        send(frm(10'h3FF), 4, 4);
        check("stall_busy", link.busy, 1);
        tick(1100);
        check("to_err_cnt", ecnt - e0, 1);
        check("to_err_time_ok", (ecyc - rise_cyc >= 1024) && (ecyc - rise_cyc <= 1030), 1);
        check("to_valid_cnt", vcnt - v0, 0);
        check("to_notes", link.notes, 10'h204);
        check("to_busy", link.busy, 0);
        frame("f3ff", 10'h3FF, 10'h1FB, 10'h000);
        v0 = vcnt;
        send(frm(10'h155), 6, 4);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mrst_notes", link.notes, 0);
        check("mrst_busy", link.busy, 0);
        tick(20);
        check("mrst_valid_cnt", vcnt - v0, 0);
        frame("f0f0", 10'h0F0, 10'h0F0, 10'h000);
`ifdef NOTE_RX_PARITY_EN
        frame("p003_ok", 10'h003, 10'h003, 10'h0F0);
        v0 = vcnt;
        e0 = ecnt;
        send({1'b1, 10'h003}, FL, 4);
        tick(12);
        check("pbad_err_cnt", ecnt - e0, 1);
        check("pbad_valid_cnt", vcnt - v0, 0);
        check("pbad_notes", link.notes, 10'h003);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
